accel_sampler: RTL

Sequencer directly upstream of SPIMaster in the vibration-measurement path. After reset it writes the three accelerometer configuration registers, then issues periodic 6-axis-byte burst reads. Each completed read is unpacked into signed X/Y/Z samples with a one-cycle valid strobe for the downstream capture/FFT logic.

---
 rtl/accel_pkg.sv | 41 ++++
 rtl/sample_timer.sv | 34 +++
 rtl/accel_sampler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared constants and types for the accelerometer sampling sequencer.
package accel_pkg;

  localparam logic [5:0] REG_BW_RATE     = 6'h2C;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATAX0      = 6'h32;

  typedef enum logic [2:0] {
    StPwrWait,
    StReq,
    StBusy,
    StRelease,
    StPublish,
    StIdle
  } state_e;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] value;
  } cfg_op_t;

  // Entry 0 is issued first.
  typedef cfg_op_t [2:0] cfg_seq_t;

  function automatic cfg_seq_t build_cfg_seq(input logic [7:0] bw_rate,
                                             input logic [7:0] data_format,
                                             input logic [7:0] power_ctl);
    cfg_seq_t seq;
    seq[0] = '{addr: REG_BW_RATE,     value: bw_rate};
    seq[1] = '{addr: REG_DATA_FORMAT, value: data_format};
    seq[2] = '{addr: REG_POWER_CTL,   value: power_ctl};
    return seq;
  endfunction

  // Byte k of the captured burst (byte 0 in the top bits).
  function automatic logic [7:0] rx_byte(input logic [47:0] data, input int unsigned k);
    return data[47 - 8 * k -: 8];
  endfunction

endpackage

// File: rtl/sample_timer.sv
// Free-running divider: counts 0..Div-1 while enabled and flags the wrap cycle.
module sample_timer #(
  parameter int unsigned Div = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] Last = 16'(Div - 1);

  logic [15:0] count_q, count_d;

  // Next count: wrap at Div-1, hold while disabled.
  always_comb begin
    count_d = count_q;
    if (enable) begin
      count_d = (count_q == Last) ? 16'd0 : count_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = enable && (count_q == Last);

endmodule

// File: rtl/accel_sampler.sv
// Configures the accelerometer over SPI, then launches periodic burst reads and
// publishes signed X/Y/Z samples.
module accel_sampler
  import accel_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV      = 1000,
  parameter int unsigned PWR_DELAY       = 4096,
  parameter logic [7:0]  BW_RATE_VAL     = 8'h0D,
  parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
  parameter logic [7:0]  POWER_CTL_VAL   = 8'h08
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               spi_enable,
  output logic               spi_rw,
  output logic [5:0]         spi_address,
  output logic [7:0]         spi_value,
  input  logic [55:0]        spi_buffer,
  input  logic               spi_ready,
  output logic               cfg_done,
  output logic signed [15:0] x,
  output logic signed [15:0] y,
  output logic signed [15:0] z,
  output logic               sample_valid,
  output logic [7:0]         sample_seq,
  output logic               overrun
);

  localparam cfg_seq_t    CfgSeq  = build_cfg_seq(BW_RATE_VAL, DATA_FORMAT_VAL, POWER_CTL_VAL);
  localparam logic [15:0] PwrLast = 16'(PWR_DELAY - 1);

  state_e             state_q, state_d;
  logic [15:0]        pwr_cnt_q, pwr_cnt_d;
  logic [1:0]         cfg_idx_q, cfg_idx_d;
  logic               is_read_q, is_read_d;
  logic [47:0]        rx_q, rx_d;
  logic               en_q, en_d;
  logic               rw_q, rw_d;
  logic [5:0]         addr_q, addr_d;
  logic [7:0]         value_q, value_d;
  logic               cfg_done_q, cfg_done_d;
  logic signed [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic               valid_q, valid_d;
  logic [7:0]         seq_q, seq_d;
  logic               overrun_q, overrun_d;
  logic               tick;
  cfg_op_t            cur_op;

  // Trailing burst byte carries no sample data.
  logic unused_byte6;
  assign unused_byte6 = ^spi_buffer[7:0];

  sample_timer #(
    .Div(SAMPLE_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .enable(cfg_done_q),
    .tick  (tick)
  );

  // Select the pending configuration write.
  always_comb begin
    cur_op = CfgSeq[2];
    case (cfg_idx_q)
      2'd0:    cur_op = CfgSeq[0];
      2'd1:    cur_op = CfgSeq[1];
      default: cur_op = CfgSeq[2];
    endcase
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    cfg_idx_d  = cfg_idx_q;
    is_read_d  = is_read_q;
    rx_d       = rx_q;
    en_d       = en_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    value_d    = value_q;
    cfg_done_d = cfg_done_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    valid_d    = 1'b0;
    seq_d      = seq_q;
    // A tick that cannot launch a read because one is still in flight.
    overrun_d  = tick && (state_q != StIdle);

    case (state_q)
      StPwrWait: begin
        if (pwr_cnt_q == PwrLast) begin
          state_d   = StReq;
          cfg_idx_d = 2'd0;
          is_read_d = 1'b0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 16'd1;
        end
      end
      StReq: begin
        en_d    = 1'b1;
        state_d = StBusy;
        if (is_read_q) begin
          rw_d    = 1'b1;
          addr_d  = REG_DATAX0;
          value_d = 8'h00;
        end else begin
          rw_d    = 1'b0;
          addr_d  = cur_op.addr;
          value_d = cur_op.value;
        end
      end
      StBusy: begin
        if (spi_ready) begin
          en_d    = 1'b0;
          state_d = StRelease;
          if (is_read_q) begin
            rx_d = spi_buffer[55:8];
          end
        end
      end
      StRelease: begin
        if (!spi_ready) begin
          if (is_read_q) begin
            state_d = StPublish;
          end else if (cfg_idx_q == 2'd2) begin
            cfg_done_d = 1'b1;
            state_d    = StIdle;
          end else begin
            cfg_idx_d = cfg_idx_q + 2'd1;
            state_d   = StReq;
          end
        end
      end
      StPublish: begin
        x_d     = {rx_byte(rx_q, 1), rx_byte(rx_q, 0)};
        y_d     = {rx_byte(rx_q, 3), rx_byte(rx_q, 2)};
        z_d     = {rx_byte(rx_q, 5), rx_byte(rx_q, 4)};
        valid_d = 1'b1;
        seq_d   = seq_q + 8'd1;
        state_d = StIdle;
      end
      StIdle: begin
        if (tick && run) begin
          is_read_d = 1'b1;
          state_d   = StReq;
        end
      end
      default: state_d = StPwrWait;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StPwrWait;
      pwr_cnt_q  <= 16'd0;
      cfg_idx_q  <= 2'd0;
      is_read_q  <= 1'b0;
      rx_q       <= 48'd0;
      en_q       <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= 6'd0;
      value_q    <= 8'd0;
      cfg_done_q <= 1'b0;
      x_q        <= 16'sd0;
      y_q        <= 16'sd0;
      z_q        <= 16'sd0;
      valid_q    <= 1'b0;
      seq_q      <= 8'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      cfg_idx_q  <= cfg_idx_d;
      is_read_q  <= is_read_d;
      rx_q       <= rx_d;
      en_q       <= en_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      value_q    <= value_d;
      cfg_done_q <= cfg_done_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      valid_q    <= valid_d;
      seq_q      <= seq_d;
      overrun_q  <= overrun_d;
    end
  end

  assign spi_enable   = en_q;
  assign spi_rw       = rw_q;
  assign spi_address  = addr_q;
  assign spi_value    = value_q;
  assign cfg_done     = cfg_done_q;
  assign x            = x_q;
  assign y            = y_q;
  assign z            = z_q;
  assign sample_valid = valid_q;
  assign sample_seq   = seq_q;
  assign overrun      = overrun_q;

endmodule
